dm_lsu_bus_if: RTL

- Registered load/store unit between the MEM stage and an OBI-style data bus (req/gnt/rvalid).
- Generates byte enables and lane-shifted write data, then sign- or zero-extends returned load data.
- Detects misaligned accesses.
- Generalised over bus data width and tolerant of grant and response wait states. Replaces the combinational data memory interface; the core stalls on lsu_ready_o / lsu_done_o.

---
 rtl/dm_lsu_bus_if.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/dm_lsu_bus_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dm_lsu_bus_if : registered load/store unit bridging MEM stage to OBI bus |
// | Optional macro DM_LSU_MISALIGNED_SPLIT_EN enables misaligned splitting.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dm_lsu_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lsu_valid_i,
  output logic                   lsu_ready_o,
  input  logic                   lsu_we_i,
  input  logic [2:0]             lsu_funct3_i,
  input  logic [ADDR_WIDTH-1:0]  lsu_addr_i,
  input  logic [31:0]            lsu_wdata_i,
  output logic [31:0]            lsu_rdata_o,
  output logic                   lsu_done_o,
  output logic                   lsu_misaligned_o,
  output logic                   lsu_bus_err_o,
  output logic                   data_req_o,
  input  logic                   data_gnt_i,
  output logic [ADDR_WIDTH-1:0]  data_addr_o,
  output logic                   data_we_o,
  output logic [BUS_WIDTH/8-1:0] data_be_o,
  output logic [BUS_WIDTH-1:0]   data_wdata_o,
  input  logic                   data_rvalid_i,
  input  logic [BUS_WIDTH-1:0]   data_rdata_i,
  input  logic                   data_err_i
);
  localparam int BYTES = BUS_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_ERR   = 3'd3,
    S_DONE  = 3'd4,
    S_REQ2  = 3'd5,
    S_RESP2 = 3'd6
  } state_t;

  state_t           r_state;
  logic [2:0]       r_funct3;
  logic             r_we;
  logic [OFF-1:0]   r_off;

  logic [1:0]              w_size;
  logic [3:0]              w_sizeMask;
  logic [OFF-1:0]          w_off;
  logic [ADDR_WIDTH-1:0]   w_alignedAddr;
  logic [BUS_WIDTH-1:0]    w_wdataRepl;
  logic [BYTES-1:0]        w_beLow;
  logic [BUS_WIDTH-1:0]    w_wdataLow;
  logic [2*BUS_WIDTH-1:0]  w_rdataWide;
  logic                    w_respLast;
  logic                    w_respErr;
  logic [31:0]             w_loadWord;
  logic [31:0]             w_loadExt;

  // size code: 0=byte, 1=half, 2=word (unused funct3 codes fall back to word)
  assign w_size        = (lsu_funct3_i[1:0] == 2'b00) ? 2'd0 :
                         (lsu_funct3_i[1:0] == 2'b01) ? 2'd1 : 2'd2;
  assign w_sizeMask    = (w_size == 2'd0) ? 4'h1 : (w_size == 2'd1) ? 4'h3 : 4'hF;
  assign w_off         = lsu_addr_i[OFF-1:0];
  assign w_alignedAddr = {lsu_addr_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
  assign w_wdataRepl   = {(BUS_WIDTH/32){lsu_wdata_i}};

`ifdef DM_LSU_MISALIGNED_SPLIT_EN
  logic [OFF+1:0]          w_nBytes;
  logic [OFF+1:0]          w_endByte;
  logic                    w_cross;
  logic [2*BYTES-1:0]      w_beWide;
  logic [2*BUS_WIDTH-1:0]  w_wdataWide;
  logic [ADDR_WIDTH-1:0]   r_addr2;
  logic [BYTES-1:0]        r_be2;
  logic [BUS_WIDTH-1:0]    r_wdata2;
  logic [BUS_WIDTH-1:0]    r_rdLow;
  logic                    r_split;
  logic                    r_err;

  // Lanes shifted past the top of the bus word spill into the following word.
  assign w_nBytes    = (OFF+2)'(1) << w_size;
  assign w_endByte   = (OFF+2)'(w_off) + w_nBytes;
  assign w_cross     = w_endByte > (OFF+2)'(BYTES);
  assign w_beWide    = (2*BYTES)'(w_sizeMask) << w_off;
  assign w_wdataWide = (2*BUS_WIDTH)'(w_wdataRepl) << {w_off, 3'b000};
  assign w_beLow     = w_beWide[BYTES-1:0];
  assign w_wdataLow  = w_wdataWide[BUS_WIDTH-1:0];
  assign w_rdataWide = (r_state == S_RESP2) ? {data_rdata_i, r_rdLow}
                                            : (2*BUS_WIDTH)'(data_rdata_i);
  assign w_respLast  = data_rvalid_i && (((r_state == S_RESP) && !r_split) || (r_state == S_RESP2));
  assign w_respErr   = data_err_i || ((r_state == S_RESP2) && r_err);
`else
  logic w_misaligned;

  assign w_misaligned = ((w_size == 2'd1) && lsu_addr_i[0]) ||
                        ((w_size == 2'd2) && (lsu_addr_i[1:0] != 2'b00));
  assign w_beLow      = BYTES'(w_sizeMask) << w_off;
  assign w_wdataLow   = w_wdataRepl << {w_off, 3'b000};
  assign w_rdataWide  = (2*BUS_WIDTH)'(data_rdata_i);
  assign w_respLast   = data_rvalid_i && (r_state == S_RESP);
  assign w_respErr    = data_err_i;
`endif

  assign w_loadWord = 32'(w_rdataWide >> {r_off, 3'b000});

  always_comb begin
    w_loadExt = w_loadWord;
    case (r_funct3)
      3'b000:  w_loadExt = {{24{w_loadWord[7]}}, w_loadWord[7:0]};
      3'b001:  w_loadExt = {{16{w_loadWord[15]}}, w_loadWord[15:0]};
      3'b100:  w_loadExt = {24'h0, w_loadWord[7:0]};
      3'b101:  w_loadExt = {16'h0, w_loadWord[15:0]};
      default: w_loadExt = w_loadWord;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_funct3         <= 3'b000;
      r_we             <= 1'b0;
      r_off            <= '0;
      lsu_ready_o      <= 1'b1;
      lsu_rdata_o      <= '0;
      lsu_done_o       <= 1'b0;
      lsu_misaligned_o <= 1'b0;
      lsu_bus_err_o    <= 1'b0;
      data_req_o       <= 1'b0;
      data_addr_o      <= '0;
      data_we_o        <= 1'b0;
      data_be_o        <= '0;
      data_wdata_o     <= '0;
`ifdef DM_LSU_MISALIGNED_SPLIT_EN
      r_addr2          <= '0;
      r_be2            <= '0;
      r_wdata2         <= '0;
      r_rdLow          <= '0;
      r_split          <= 1'b0;
      r_err            <= 1'b0;
`endif
    end else begin
      if (w_respLast) begin
        if (!r_we) lsu_rdata_o <= w_loadExt;
        lsu_bus_err_o <= w_respErr;
        lsu_done_o    <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (lsu_valid_i) begin
            lsu_ready_o  <= 1'b0;
            r_funct3     <= lsu_funct3_i;
            r_we         <= lsu_we_i;
            r_off        <= w_off;
            data_addr_o  <= w_alignedAddr;
            data_we_o    <= lsu_we_i;
            data_be_o    <= w_beLow;
            data_wdata_o <= w_wdataLow;
`ifdef DM_LSU_MISALIGNED_SPLIT_EN
            r_split      <= w_cross;
            r_addr2      <= w_alignedAddr + ADDR_WIDTH'(BYTES);
            r_be2        <= w_beWide[2*BYTES-1:BYTES];
            r_wdata2     <= w_wdataWide[2*BUS_WIDTH-1:BUS_WIDTH];
            r_err        <= 1'b0;
            data_req_o   <= 1'b1;
            r_state      <= S_REQ;
`else
            data_req_o   <= !w_misaligned;
            r_state      <= w_misaligned ? S_ERR : S_REQ;
`endif
          end
        end
        S_REQ: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (data_rvalid_i) begin
`ifdef DM_LSU_MISALIGNED_SPLIT_EN
            if (r_split) begin
              r_rdLow      <= data_rdata_i;
              r_err        <= data_err_i;
              data_addr_o  <= r_addr2;
              data_be_o    <= r_be2;
              data_wdata_o <= r_wdata2;
              data_req_o   <= 1'b1;
              r_state      <= S_REQ2;
            end else begin
              r_state      <= S_DONE;
            end
`else
            r_state <= S_DONE;
`endif
          end
        end
`ifdef DM_LSU_MISALIGNED_SPLIT_EN
        S_REQ2: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            r_state    <= S_RESP2;
          end
        end
        S_RESP2: begin
          if (data_rvalid_i) r_state <= S_DONE;
        end
`endif
        S_ERR: begin
          lsu_done_o       <= 1'b1;
          lsu_misaligned_o <= 1'b1;
          r_state          <= S_DONE;
        end
        S_DONE: begin
          lsu_done_o       <= 1'b0;
          lsu_misaligned_o <= 1'b0;
          lsu_bus_err_o    <= 1'b0;
          lsu_ready_o      <= 1'b1;
          r_state          <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
